// File: rtl/xge_pkt_gen_pkg.sv
// Shared types, widths and length helpers for the 10GE TX packet generator.
package xge_pkt_gen_pkg;

  localparam int LEN_W  = 14;
  localparam int NUM_W  = 16;
  localparam int IPG_W  = 8;
  localparam int CNT_W  = 32;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

  // Valid bytes in the eop word; 0 means all eight.
  function automatic logic [2:0] mod_of(input logic [LEN_W-1:0] len);
    return len[2:0];
  endfunction

  function automatic logic [LEN_W-1:0] words_of(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(7);
    return LEN_W'(sum >> 3);
  endfunction

endpackage

// File: rtl/xge_pkt_gen_pattern.sv
// Combinational payload word builder: byte k of packet p is (p + k) mod 256,
// bytes past the packet length are zero. Define XGE_PKT_GEN_SEQNUM_EN to
// overwrite bytes 0..3 with the big-endian burst sequence number.
module xge_pkt_gen_pattern
  import xge_pkt_gen_pkg::*;
(
  input  logic [31:0]       pkt_idx,
  input  logic [LEN_W-1:0]  word_idx,
  input  logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] data
);

  logic seq_en;

`ifdef XGE_PKT_GEN_SEQNUM_EN
  assign seq_en = (word_idx == '0) && (len >= LEN_W'(4));
`else
  assign seq_en = 1'b0;
`endif

  always_comb begin
    logic [LEN_W+2:0] k;
    k    = '0;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      k = {word_idx, 3'(i)};
      if (k < {3'b000, len})
        data[DATA_W-1-8*i -: 8] = pkt_idx[7:0] + k[7:0];
    end
    if (seq_en)
      data[63:32] = pkt_idx;
  end

endmodule

// File: rtl/xge_pkt_gen.sv
// Packet burst source for the 10GE MAC TX enqueue interface, all outputs registered.
// Optional sequence-number insert: define XGE_PKT_GEN_SEQNUM_EN.
module xge_pkt_gen
  import xge_pkt_gen_pkg::*;
#(
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 9600
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic [IPG_W-1:0]  cfg_ipg,
  input  logic              pkt_tx_full,
  output logic [DATA_W-1:0] pkt_tx_data,
  output logic              pkt_tx_val,
  output logic              pkt_tx_sop,
  output logic              pkt_tx_eop,
  output logic [2:0]        pkt_tx_mod,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_sent_cnt
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, words_q, words_d, word_q, word_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [IPG_W-1:0]   ipg_q, ipg_d, gap_q, gap_d;
  logic [31:0]        pkt_q, pkt_d;
  logic               stop_seen_q, stop_seen_d;
  logic               end_pend_q, end_pend_d;

  logic [DATA_W-1:0]  data_d;
  logic               val_d, sop_d, eop_d, busy_d, done_d;
  logic [2:0]         mod_d;
  logic [CNT_W-1:0]   cnt_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [DATA_W-1:0]  pat_data;
  logic               last_word, num_hit;

  assign len_clamp = (cfg_len < MIN_L) ? MIN_L : (cfg_len > MAX_L) ? MAX_L : cfg_len;
  assign last_word = (word_q == words_q - LEN_W'(1));
  assign num_hit   = (num_q != '0) && ((pkt_q + 32'd1) == {16'b0, num_q});

  xge_pkt_gen_pattern u_pattern (
    .pkt_idx  (pkt_q),
    .word_idx (word_q),
    .len      (len_q),
    .data     (pat_data)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    len_d       = len_q;
    words_d     = words_q;
    num_d       = num_q;
    ipg_d       = ipg_q;
    gap_d       = gap_q;
    word_d      = word_q;
    pkt_d       = pkt_q;
    stop_seen_d = stop_seen_q;
    end_pend_d  = end_pend_q;
    busy_d      = busy;
    done_d      = 1'b0;
    cnt_d       = pkt_sent_cnt;
    data_d      = '0;
    val_d       = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    mod_d       = '0;

    case (state_q)
      IDLE: begin
        // The burst is closed one cycle after its last eop (or after a stop in GAP).
        if (end_pend_q) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          end_pend_d = 1'b0;
        end else if (start) begin
          len_d       = len_clamp;
          words_d     = words_of(len_clamp);
          num_d       = cfg_num;
          ipg_d       = cfg_ipg;
          word_d      = '0;
          pkt_d       = '0;
          stop_seen_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = DATA;
        end
      end

      DATA: begin
        if (stop) stop_seen_d = 1'b1;
        if (!pkt_tx_full) begin
          val_d  = 1'b1;
          data_d = pat_data;
          sop_d  = (word_q == '0);
          if (last_word) begin
            eop_d  = 1'b1;
            mod_d  = mod_of(len_q);
            cnt_d  = pkt_sent_cnt + 32'd1;
            pkt_d  = pkt_q + 32'd1;
            word_d = '0;
            if (stop || stop_seen_q || num_hit) begin
              state_d     = IDLE;
              end_pend_d  = 1'b1;
              stop_seen_d = 1'b0;
            end else if (ipg_q != '0) begin
              state_d = GAP;
              gap_d   = ipg_q;
            end
          end else begin
            word_d = word_q + LEN_W'(1);
          end
        end
      end

      GAP: begin
        if (stop) begin
          state_d    = IDLE;
          end_pend_d = 1'b1;
        end else if (gap_q == IPG_W'(1)) begin
          state_d = DATA;
        end else begin
          gap_d = gap_q - IPG_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q      <= IDLE;
      len_q        <= '0;
      words_q      <= '0;
      num_q        <= '0;
      ipg_q        <= '0;
      gap_q        <= '0;
      word_q       <= '0;
      pkt_q        <= '0;
      stop_seen_q  <= 1'b0;
      end_pend_q   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pkt_sent_cnt <= '0;
      pkt_tx_data  <= '0;
      pkt_tx_val   <= 1'b0;
      pkt_tx_sop   <= 1'b0;
      pkt_tx_eop   <= 1'b0;
      pkt_tx_mod   <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      num_q        <= num_d;
      ipg_q        <= ipg_d;
      gap_q        <= gap_d;
      word_q       <= word_d;
      pkt_q        <= pkt_d;
      stop_seen_q  <= stop_seen_d;
      end_pend_q   <= end_pend_d;
      busy         <= busy_d;
      done         <= done_d;
      pkt_sent_cnt <= cnt_d;
      pkt_tx_data  <= data_d;
      pkt_tx_val   <= val_d;
      pkt_tx_sop   <= sop_d;
      pkt_tx_eop   <= eop_d;
      pkt_tx_mod   <= mod_d;
    end
  end

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Scoreboard bench for xge_pkt_gen: expected words are queued at start and
// popped by a negedge monitor; scenario tasks check timing, counters and control.
module tb_xge_pkt_gen;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25 = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] cfg_len = '0;
  logic [15:0] cfg_num = '0;
  logic [7:0]  cfg_ipg = '0;
  logic        pkt_tx_full = 1'b0;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        busy, done;
  logic [31:0] pkt_sent_cnt;

  xge_pkt_gen dut (
    .clk_156m25   (clk_156m25),
    .reset_156m25 (reset_156m25),
    .start        (start),
    .stop         (stop),
    .cfg_len      (cfg_len),
    .cfg_num      (cfg_num),
    .cfg_ipg      (cfg_ipg),
    .pkt_tx_full  (pkt_tx_full),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .busy         (busy),
    .done         (done),
    .pkt_sent_cnt (pkt_sent_cnt)
  );

  always #3 clk_156m25 = ~clk_156m25;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  word_t exp_q[$];
  int    gap_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    exp_cnt = 0;
  int    start_cyc = 0;

  int    words_seen = 0;
  int    bubbles = 0;
  int    done_cnt = 0;
  int    last_eop_cyc = 0;
  int    last_sop_cyc = 0;
  bit    in_pkt = 1'b0;
  bit    have_eop = 1'b0;
  word_t mon_e;

  always @(posedge clk_156m25) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid word.
  always @(negedge clk_156m25) begin
    if (reset_156m25) begin
      exp_q.delete();
      in_pkt   = 1'b0;
      have_eop = 1'b0;
    end else if (pkt_tx_val) begin
      words_seen++;
      if (pkt_tx_sop) begin
        last_sop_cyc = cyc;
        in_pkt = 1'b1;
        if (have_eop) gap_q.push_back(cyc - last_eop_cyc - 1);
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, none required",
                 pkt_tx_data, pkt_tx_sop, pkt_tx_eop);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (pkt_tx_data !== mon_e.data) begin
          n_err++;
          $display("FAIL word_data: got %h, required %h", pkt_tx_data, mon_e.data);
        end
        n_cmp++;
        if ({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== {mon_e.sop, mon_e.eop, mon_e.mod}) begin
          n_err++;
          $display("FAIL word_ctrl: got sop=%b eop=%b mod=%0d, required sop=%b eop=%b mod=%0d",
                   pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, mon_e.sop, mon_e.eop, mon_e.mod);
        end
      end
      if (pkt_tx_eop) begin
        in_pkt = 1'b0;
        have_eop = 1'b1;
        last_eop_cyc = cyc;
      end
    end else if (in_pkt) begin
      bubbles++;
    end
    if (!reset_156m25 && done) begin
      done_cnt++;
      have_eop = 1'b0;
    end
  end

  function automatic int clamp_len(input int len);
    return (len < 1) ? 1 : (len > 9600) ? 9600 : len;
  endfunction

  task automatic push_packet(input int p, input int len);
    int    w_n;
    word_t e;
    w_n = (len + 7) / 8;
    for (int w = 0; w < w_n; w++) begin
      e.data = '0;
      for (int i = 0; i < 8; i++) begin
        int k;
        k = 8 * w + i;
        if (k < len) e.data[63-8*i -: 8] = 8'((p + k) % 256);
      end
`ifdef XGE_PKT_GEN_SEQNUM_EN
      if (w == 0 && len >= 4) e.data[63:32] = 32'(p);
`endif
      e.sop = (w == 0);
      e.eop = (w == w_n - 1);
      e.mod = e.eop ? 3'(len % 8) : 3'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_burst(input int len, input int num, input int ipg, input int npkts);
    for (int p = 0; p < npkts; p++) push_packet(p, clamp_len(len));
    @(posedge clk_156m25); #1;
    cfg_len = 14'(len);
    cfg_num = 16'(num);
    cfg_ipg = 8'(ipg);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk_156m25); #1;
    start = 1'b0;
  endtask

  task automatic wait_words(input int target, input string name);
    int n = 0;
    while (words_seen < target && n < 2000) begin
      @(negedge clk_156m25); #1;
      n++;
    end
    if (words_seen < target) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d words, required %0d", name, words_seen, target);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk_156m25);
      n++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", name, budget);
    end else begin
      if (cyc - last_eop_cyc !== 1) begin
        n_err++;
        $display("FAIL %s_done_delay: got %0d cycles after eop, required 1", name, cyc - last_eop_cyc);
      end
      @(negedge clk_156m25); #1;
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL %s_after_done: got done=%b busy=%b, required 0 0", name, done, busy);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_words_left: got %0d expected words unseen, required 0", name, exp_q.size());
    end
    n_cmp++;
    if (pkt_sent_cnt !== 32'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s_pkt_cnt: got %0d, required %0d", name, pkt_sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset_156m25 = 1'b1;
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25);
    n_cmp++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got val=%b sop=%b eop=%b mod=%0d, required all 0",
               pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod);
    end
    n_cmp++;
    if (pkt_tx_data !== 64'd0) begin
      n_err++; $display("FAIL reset_data: got %h, required 0", pkt_tx_data);
    end
    n_cmp++;
    if ({busy, done} !== 2'b00 || pkt_sent_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_status: got busy=%b done=%b cnt=%0d, required 0 0 0", busy, done, pkt_sent_cnt);
    end
    @(posedge clk_156m25); #1;
    reset_156m25 = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_single();
    int w0;
    w0 = words_seen;
    exp_cnt += 1;
    start_burst(64, 1, 0, 1);
    wait_done(100, "single");
    n_cmp++;
    if (words_seen - w0 !== 8) begin
      n_err++; $display("FAIL single_words: got %0d, required 8", words_seen - w0);
    end
    n_cmp++;
    if (last_sop_cyc - start_cyc !== 2) begin
      n_err++; $display("FAIL single_latency: got sop %0d cycles after start drive, required 2",
                        last_sop_cyc - start_cyc);
    end
  endtask

  task automatic test_ipg();
    gap_q.delete();
    exp_cnt += 3;
    start_burst(13, 3, 4, 3);
    wait_done(200, "ipg");
    n_cmp++;
    if (gap_q.size() !== 2) begin
      n_err++; $display("FAIL ipg_gap_count: got %0d, required 2", gap_q.size());
    end
    foreach (gap_q[i]) begin
      n_cmp++;
      if (gap_q[i] !== 4) begin
        n_err++; $display("FAIL ipg_gap_len: got %0d idle cycles, required 4", gap_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int w0, b0;
    w0 = words_seen;
    b0 = bubbles;
    exp_cnt += 1;
    start_burst(100, 1, 0, 1);
    wait_words(w0 + 4, "bp");
    pkt_tx_full = 1'b1;
    repeat (5) @(posedge clk_156m25);
    #1 pkt_tx_full = 1'b0;
    wait_done(200, "bp");
    n_cmp++;
    if (words_seen - w0 !== 13) begin
      n_err++; $display("FAIL bp_words: got %0d, required 13", words_seen - w0);
    end
    n_cmp++;
    if (bubbles - b0 !== 5) begin
      n_err++; $display("FAIL bp_bubbles: got %0d idle cycles in packet, required 5", bubbles - b0);
    end
  endtask

  task automatic test_short();
    int w0;
    @(posedge clk_156m25); #1 stop = 1'b1;
    @(posedge clk_156m25); #1 stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_stop_busy: got %b, required 0", busy);
    end
    w0 = words_seen;
    exp_cnt += 1;
    start_burst(3, 1, 0, 1);
    wait_done(50, "len3");
    exp_cnt += 1;
    start_burst(0, 1, 0, 1);
    wait_done(50, "len0");
    n_cmp++;
    if (words_seen - w0 !== 2) begin
      n_err++; $display("FAIL short_words: got %0d, required 2", words_seen - w0);
    end
    exp_cnt += 2;
    start_burst(9, 2, 1, 2);
    wait_done(50, "len9");
    w0 = words_seen;
    exp_cnt += 1;
    start_burst(16383, 1, 0, 1);
    wait_done(1400, "maxlen");
    n_cmp++;
    if (words_seen - w0 !== 1200) begin
      n_err++; $display("FAIL maxlen_words: got %0d, required 1200", words_seen - w0);
    end
  endtask

  task automatic test_stop_and_busy();
    int w0;
    w0 = words_seen;
    exp_cnt += 3;
    start_burst(16, 0, 0, 3);
    wait_words(w0 + 1, "busy_start");
    cfg_len = 14'd5;
    cfg_num = 16'd1;
    start = 1'b1;
    @(posedge clk_156m25); #1 start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_flag: got %b, required 1", busy);
    end
    wait_words(w0 + 5, "stop");
    stop = 1'b1;
    @(posedge clk_156m25); #1 stop = 1'b0;
    wait_done(100, "stop");
    n_cmp++;
    if (words_seen - w0 !== 6) begin
      n_err++; $display("FAIL stop_words: got %0d, required 6", words_seen - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = words_seen;
    start_burst(64, 1, 0, 1);
    wait_words(w0 + 3, "rst_mid");
    d0 = done_cnt;
    reset_156m25 = 1'b1;
    @(posedge clk_156m25); #1;
    n_cmp++;
    if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got val=%b sop=%b eop=%b busy=%b, required all 0",
               pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy);
    end
    repeat (2) @(posedge clk_156m25);
    #1 reset_156m25 = 1'b0;
    repeat (5) @(posedge clk_156m25);
    #1;
    n_cmp++;
    if (done_cnt !== d0 || pkt_sent_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_status: got done pulses=%0d cnt=%0d, required 0 0", done_cnt - d0, pkt_sent_cnt);
    end
    exp_cnt = 1;
    start_burst(8, 1, 0, 1);
    wait_done(50, "after_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_ipg();
    test_backpressure();
    test_short();
    test_stop_and_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
